// File: rtl/dc_pkg.sv
// Shared types and register map for the delayed combiner.
// Mode/state encodings and bus addresses live here so the top and bench agree.
package dc_pkg;

   typedef enum logic [1:0] {
      MODE_OR  = 2'd0,
      MODE_AND = 2'd1,
      MODE_XOR = 2'd2,
      MODE_ADD = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam logic [3:0] WA_CTRL    = 4'h8;
   localparam logic [3:0] WA_DELAY   = 4'h9;
   localparam logic [3:0] WA_OVF_CLR = 4'hA;

   localparam logic [3:0] RA_FULL_N      = 4'h0;
   localparam logic [3:0] RA_EMPTY_N     = 4'h1;
   localparam logic [3:0] RA_OUT_EMPTY_N = 4'h2;
   localparam logic [3:0] RA_POP         = 4'h3;
   localparam logic [3:0] RA_CTRL        = 4'h4;
   localparam logic [3:0] RA_DELAY       = 4'h5;
   localparam logic [3:0] RA_OVF         = 4'h6;
   localparam logic [3:0] RA_OCC         = 4'h7;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: D_OUT always shows the head so the combiner can
// reduce heads combinationally. Enqueue on full and dequeue on empty are ignored.
module sync_fifo
   import dc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENQ,
   input  logic             DEQ,
   input  logic [WIDTH-1:0] D_IN,
   output logic [WIDTH-1:0] D_OUT,
   output logic             FULL_N,
   output logic             EMPTY_N,
   output logic [CW-1:0]    COUNT
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_enq;
   logic             do_deq;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign FULL_N  = (count_reg != CW'(DEPTH));
   assign EMPTY_N = (count_reg != '0);
   assign COUNT   = count_reg;
   assign D_OUT   = mem[rd_ptr_reg];
   assign do_enq  = ENQ && FULL_N;
   assign do_deq  = DEQ && EMPTY_N;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_enq) wr_ptr_reg <= bump(wr_ptr_reg);
         if (do_deq) rd_ptr_reg <= bump(rd_ptr_reg);
         case ({do_enq, do_deq})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge CLK) begin
      if (do_enq) mem[wr_ptr_reg] <= D_IN;
   end

endmodule

// File: rtl/delayed_combiner.sv
// Timer-gated reducer: after DELAY cycles, heads of all channel FIFOs are combined
// (OR/AND/XOR/ADD) and queued into an output FIFO drained through the read port.
module delayed_combiner
   import dc_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NCH       = 2,
   parameter int IN_DEPTH  = 2,
   parameter int OUT_DEPTH = 2,
   parameter int CNT_W     = 8,
   parameter int DEF_DELAY = 50
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [3:0]       write_address,
   input  logic [WIDTH-1:0] write_data,
   input  logic             write_en,
   output logic             write_rdy,
   input  logic [3:0]       read_address,
   input  logic             read_en,
   output logic [WIDTH-1:0] read_data,
   output logic             read_rdy,
   output logic             busy
);

   localparam int OCW = $clog2(OUT_DEPTH + 1);

   logic             en_reg;
   mode_e            mode_reg;
   logic [CNT_W-1:0] delay_reg;
   logic [CNT_W-1:0] timer_reg;
   logic [NCH-1:0]   ovf_reg;
   state_e           state_reg;

   logic [NCH-1:0]   ch_sel;
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   ch_full_n;
   logic [NCH-1:0]   ch_empty_n;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] out_head;
   logic             out_full_n;
   logic             out_empty_n;
   logic [OCW-1:0]   out_count;
   logic             fire;
   logic             pop_req;

   function automatic logic [WIDTH-1:0] combine(input mode_e m,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (m)
         MODE_AND: return a & b;
         MODE_XOR: return a ^ b;
         MODE_ADD: return a + b;
         default:  return a | b;
      endcase
   endfunction

   // Per-channel FIFO plus one stage of the reduction chain.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] head;
      logic [WIDTH-1:0] acc;

      assign ch_sel[gi] = (write_address == 4'(gi));
      assign push[gi]   = write_en && ch_sel[gi];

      sync_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
         .CLK     (CLK),
         .RST     (RST),
         .ENQ     (push[gi]),
         .DEQ     (fire),
         .D_IN    (write_data),
         .D_OUT   (head),
         .FULL_N  (ch_full_n[gi]),
         .EMPTY_N (ch_empty_n[gi]),
         .COUNT   ()
      );

      if (gi == 0) begin : g_first
         assign acc = head;
      end else begin : g_next
         assign acc = combine(mode_reg, g_ch[gi-1].acc, head);
      end
   end

   assign result = g_ch[NCH-1].acc;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .ENQ     (fire),
      .DEQ     (pop_req),
      .D_IN    (result),
      .D_OUT   (out_head),
      .FULL_N  (out_full_n),
      .EMPTY_N (out_empty_n),
      .COUNT   (out_count)
   );

   // Registered FULL_N is used on purpose: a same-cycle POP does not free a slot.
   assign fire      = (state_reg == ST_WAIT) && (&ch_empty_n) && out_full_n;
   assign pop_req   = read_en && (read_address == RA_POP);
   assign write_rdy = ~|(ch_sel & ~ch_full_n);
   assign read_rdy  = 1'b1;
   assign busy      = (state_reg == ST_WAIT);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         en_reg    <= 1'b1;
         mode_reg  <= MODE_OR;
         delay_reg <= CNT_W'(DEF_DELAY);
         ovf_reg   <= '0;
      end else begin
         if (write_en && write_address == WA_CTRL) begin
            en_reg   <= write_data[2];
            mode_reg <= mode_e'(write_data[1:0]);
         end
         if (write_en && write_address == WA_DELAY)
            delay_reg <= CNT_W'(write_data);
         ovf_reg <= (ovf_reg & ~((write_en && write_address == WA_OVF_CLR) ?
                                 NCH'(write_data) : '0))
                    | (push & ~ch_full_n);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= ST_COUNT;
         timer_reg <= '0;
      end else if (!en_reg) begin
         state_reg <= ST_IDLE;
         timer_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_reg <= ST_COUNT;
               timer_reg <= '0;
            end
            ST_COUNT: begin
               if (timer_reg >= delay_reg) state_reg <= ST_WAIT;
               else                        timer_reg <= timer_reg + 1'b1;
            end
            ST_WAIT: begin
               // With zero delay stay armed so back-to-back fires are possible.
               if (fire) begin
                  timer_reg <= '0;
                  state_reg <= (delay_reg == '0) ? ST_WAIT : ST_COUNT;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      read_data = '0;
      case (read_address)
         RA_FULL_N:      read_data = WIDTH'(ch_full_n);
         RA_EMPTY_N:     read_data = WIDTH'(ch_empty_n);
         RA_OUT_EMPTY_N: read_data = WIDTH'(out_empty_n);
         RA_POP:         read_data = out_empty_n ? out_head : '0;
         RA_CTRL:        read_data = WIDTH'({en_reg, mode_reg});
         RA_DELAY:       read_data = WIDTH'(delay_reg);
         RA_OVF:         read_data = WIDTH'(ovf_reg);
         RA_OCC:         read_data = WIDTH'(out_count);
         default:        read_data = '0;
      endcase
   end

endmodule

// File: tb/tb_delayed_combiner.sv
// Directed-plus-random bench for delayed_combiner; a queue model predicts every
// popped result from the operator rules, and each comparison is an immediate assertion.
module tb_delayed_combiner;

   localparam int WIDTH    = 8;
   localparam int NCH      = 2;
   localparam int IN_DEPTH = 2;
   localparam int DEFD     = 50;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [3:0]       write_address = '0;
   logic [WIDTH-1:0] write_data = '0;
   logic             write_en = 1'b0;
   logic             write_rdy;
   logic [3:0]       read_address = '0;
   logic             read_en = 1'b0;
   logic [WIDTH-1:0] read_data;
   logic             read_rdy;
   logic             busy;

   delayed_combiner dut (
      .CLK           (CLK),
      .RST           (RST),
      .write_address (write_address),
      .write_data    (write_data),
      .write_en      (write_en),
      .write_rdy     (write_rdy),
      .read_address  (read_address),
      .read_en       (read_en),
      .read_data     (read_data),
      .read_rdy      (read_rdy),
      .busy          (busy)
   );

   always #5 CLK = ~CLK;

   int total  = 0;
   int passed = 0;

   logic [7:0] chq [NCH][$];
   logic [7:0] outq [$];
   int         cur_mode = 0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] ref_op(input int m, input logic [7:0] a, input logic [7:0] b);
      case (m)
         0: return a | b;
         1: return a & b;
         2: return a ^ b;
         default: return 8'((int'(a) + int'(b)) % 256);
      endcase
   endfunction

   task automatic model_fire();
      logic [7:0] acc;
      acc = chq[0].pop_front();
      for (int i = 1; i < NCH; i++) acc = ref_op(cur_mode, acc, chq[i].pop_front());
      outq.push_back(acc);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, output logic rdy);
      @(negedge CLK);
      write_address = a;
      write_data    = d;
      write_en      = 1'b1;
      #1 rdy = write_rdy;
      @(negedge CLK);
      write_en = 1'b0;
   endtask

   task automatic push_ch(input int i, input logic [7:0] d, output logic rdy);
      wr(4'(i), d, rdy);
      if (chq[i].size() < IN_DEPTH) chq[i].push_back(d);
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] v);
      @(negedge CLK);
      read_address = a;
      #1 v = read_data;
   endtask

   task automatic pop(output logic [7:0] v);
      @(negedge CLK);
      read_address = 4'h3;
      read_en      = 1'b1;
      #1 v = read_data;
      @(negedge CLK);
      read_en = 1'b0;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] v;
      logic [7:0] e;
      pop(v);
      e = (outq.size() > 0) ? outq.pop_front() : 8'h00;
      check(tag, v, e);
   endtask

   task automatic wait_out(input int max, output int n, output logic [7:0] v);
      n = 0;
      v = '0;
      while (n < max && v != 8'h01) begin
         rd(4'h2, v);
         n++;
      end
   endtask

   initial begin
      logic [7:0] v;
      logic       rdy;
      int         n;
      logic [7:0] a, b;
      logic [7:0] dir_tab [3][4];

      dir_tab[0] = '{8'd3, 8'hC8, 8'h64, 8'h2C};
      dir_tab[1] = '{8'd1, 8'hAA, 8'h0F, 8'h0A};
      dir_tab[2] = '{8'd2, 8'hFF, 8'h0F, 8'hF0};

      // Reset state
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_write_rdy", write_rdy, 1'b1);
      check("rst_read_rdy", read_rdy, 1'b1);
      rd(4'h0, v); check("rst_full_n", v, 8'h03);
      rd(4'h1, v); check("rst_empty_n", v, 8'h00);
      rd(4'h2, v); check("rst_out_empty_n", v, 8'h00);
      rd(4'h3, v); check("rst_pop", v, 8'h00);
      rd(4'h4, v); check("rst_ctrl", v, 8'h04);
      rd(4'h5, v); check("rst_delay", v, 8'(DEFD));
      rd(4'h6, v); check("rst_ovf", v, 8'h00);
      rd(4'h7, v); check("rst_occ", v, 8'h00);

      // Default delay, OR mode
      push_ch(0, 8'h0F, rdy);
      push_ch(1, 8'hF0, rdy);
      rd(4'h1, v); check("push_empty_n", v, 8'h03);
      model_fire();
      wait_out(60, n, v);
      check("or_first_fire", v, 8'h01);
      pop_check("or_pop");
      rd(4'h2, v); check("or_drained", v, 8'h00);

      // Zero delay, directed modes
      wr(4'h9, 8'h00, rdy);
      for (int k = 0; k < 3; k++) begin
         cur_mode = int'(dir_tab[k][0]);
         wr(4'h8, 8'h04 | dir_tab[k][0], rdy);
         push_ch(0, dir_tab[k][1], rdy);
         push_ch(1, dir_tab[k][2], rdy);
         model_fire();
         wait_out(10, n, v);
         check("dir_fire", v, 8'h01);
         pop(v);
         check("dir_pop", v, dir_tab[k][3]);
         void'(outq.pop_front());
      end

      // Randomised operands and modes
      for (int k = 0; k < 16; k++) begin
         cur_mode = int'($urandom_range(0, 3));
         wr(4'h8, 8'(4 + cur_mode), rdy);
         a = 8'($urandom);
         b = 8'($urandom);
         push_ch(0, a, rdy);
         push_ch(1, b, rdy);
         model_fire();
         wait_out(10, n, v);
         check("rnd_fire", v, 8'h01);
         pop_check("rnd_pop");
      end

      // Overflow on a full channel
      wr(4'h8, 8'h00, rdy);
      cur_mode = 0;
      push_ch(0, 8'($urandom), rdy);
      push_ch(0, 8'($urandom), rdy);
      push_ch(0, 8'h55, rdy);
      check("ovf_write_rdy", rdy, 1'b0);
      rd(4'h0, v); check("ovf_full_n", v, 8'h02);
      rd(4'h6, v); check("ovf_sticky", v, 8'h01);
      wr(4'hA, 8'h01, rdy);
      rd(4'h6, v); check("ovf_cleared", v, 8'h00);

      // Output FIFO back-pressure
      push_ch(1, 8'($urandom), rdy);
      push_ch(1, 8'($urandom), rdy);
      wr(4'h8, 8'h04, rdy);
      model_fire();
      model_fire();
      repeat (6) @(negedge CLK);
      rd(4'h7, v); check("bp_occ_two", v, 8'h02);
      push_ch(0, 8'($urandom), rdy);
      push_ch(1, 8'($urandom), rdy);
      model_fire();
      repeat (4) @(negedge CLK);
      #1 check("bp_busy", busy, 1'b1);
      rd(4'h7, v); check("bp_held", v, 8'h02);
      pop_check("bp_pop1");
      rd(4'h7, v); check("bp_refill", v, 8'h02);
      pop_check("bp_pop2");
      pop_check("bp_pop3");
      rd(4'h2, v); check("bp_drained", v, 8'h00);

      // Disable mid-count, then re-enable
      wr(4'h9, 8'd20, rdy);
      wr(4'h8, 8'h00, rdy);
      wr(4'h8, 8'h04, rdy);
      repeat (5) @(negedge CLK);
      wr(4'h8, 8'h00, rdy);
      push_ch(0, 8'($urandom), rdy);
      push_ch(1, 8'($urandom), rdy);
      repeat (200) @(negedge CLK);
      rd(4'h2, v); check("dis_no_fire", v, 8'h00);
      rd(4'h1, v); check("dis_held", v, 8'h03);
      wr(4'h8, 8'h04, rdy);
      model_fire();
      wait_out(60, n, v);
      check("reen_fire", v, 8'h01);
      check("reen_latency_ok", (n >= 21 && n <= 25), 1'b1);
      pop_check("reen_pop");

      // Reset while holding data
      wr(4'h9, 8'h00, rdy);
      push_ch(0, 8'($urandom), rdy);
      push_ch(1, 8'($urandom), rdy);
      model_fire();
      wait_out(10, n, v);
      wr(4'h8, 8'h00, rdy);
      push_ch(0, 8'($urandom), rdy);
      push_ch(1, 8'($urandom), rdy);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < NCH; i++) chq[i].delete();
      outq.delete();
      rd(4'h0, v); check("mid_rst_full_n", v, 8'h03);
      rd(4'h1, v); check("mid_rst_empty_n", v, 8'h00);
      rd(4'h2, v); check("mid_rst_out_empty_n", v, 8'h00);
      pop_check("mid_rst_pop");
      rd(4'h7, v); check("mid_rst_occ", v, 8'h00);
      rd(4'h4, v); check("mid_rst_ctrl", v, 8'h04);
      rd(4'h5, v); check("mid_rst_delay", v, 8'(DEFD));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
